// File: rtl/frame_pkg.sv
// Shared types and sizing for the ping-pong frame sequencer.
package frame_pkg;

    localparam int WIDTH  = 16;
    localparam int LANES  = 8;
    localparam int LIDX_W = $clog2(LANES);
    localparam int LEN_W  = LIDX_W + 1;

    typedef logic signed [WIDTH-1:0] sample_t;
    typedef sample_t [0:LANES-1]     frame_t;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_e;

endpackage

// File: rtl/frame_bank.sv
// One frame buffer bank: lane storage, fill state and committed length.
module frame_bank
    import frame_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr_en,
    input  logic [LIDX_W-1:0] i_wr_idx,
    input  sample_t           i_wr_data,
    input  logic              i_zero_en,
    input  logic [LEN_W-1:0]  i_zero_from,
    input  logic              i_commit,
    input  logic [LEN_W-1:0]  i_commit_len,
    input  logic              i_release,
    output bank_state_e       o_state,
    output logic [LEN_W-1:0]  o_len,
    output frame_t            o_data
);

    bank_state_e      r_state;
    bank_state_e      w_state_nxt;
    logic [LEN_W-1:0] r_len;
    frame_t           r_data;
    frame_t           w_data_nxt;

    // Bank state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: a commit overrides the write that may accompany it
    always_comb begin
        w_state_nxt = r_state;
        if (i_release) w_state_nxt = EMPTY;
        if (i_wr_en)   w_state_nxt = FILLING;
        if (i_commit)  w_state_nxt = FULL;
    end

    // State-derived outputs
    always_comb begin
        o_state = r_state;
        o_len   = r_len;
        o_data  = r_data;
    end

    // Lane update: written lanes always sit below the zero-fill start index
    always_comb begin
        w_data_nxt = r_data;
        for (int i = 0; i < LANES; i++) begin
            if (i_wr_en && (i_wr_idx == LIDX_W'(i))) w_data_nxt[i] = i_wr_data;
            if (i_zero_en && (LEN_W'(i) >= i_zero_from)) w_data_nxt[i] = '0;
        end
    end

    // Lane storage and committed length
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_len  <= '0;
        end else begin
            r_data <= w_data_nxt;
            if (i_commit) r_len <= i_commit_len;
        end
    end

endmodule

// File: rtl/frame_seq_ctrl.sv
// Serial-to-frame sequencer with two ping-pong banks and a valid/ready frame port.
module frame_seq_ctrl
    import frame_pkg::*;
#(
    parameter int SEQW = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  sample_t          in_data,
    input  logic             flush,
    output logic             frame_valid,
    input  logic             frame_ready,
    output frame_t           frame_data,
    output logic [LEN_W-1:0] frame_len,
    output logic [SEQW-1:0]  frame_seq,
    output logic [7:0]       ovf_cnt
);

    logic             r_wr_sel;
    logic             r_rd_sel;
    logic [LEN_W-1:0] r_count;
    logic [SEQW-1:0]  r_seq;
    logic [7:0]       r_ovf;

    bank_state_e      w_state [2];
    logic [LEN_W-1:0] w_len   [2];
    frame_t           w_data  [2];

    logic             w_accept;
    logic             w_complete;
    logic             w_flush_commit;
    logic             w_commit;
    logic             w_xfer;
    logic [LEN_W-1:0] w_count_acc;

    // Handshake decode; the post-accept count doubles as the commit length (LANES on completion)
    always_comb begin
        in_ready       = (w_state[r_wr_sel] != FULL);
        w_accept       = in_valid && in_ready;
        w_count_acc    = r_count + LEN_W'(w_accept);
        w_complete     = w_accept && (r_count == LEN_W'(LANES - 1));
        w_flush_commit = flush && !w_complete && (w_count_acc != '0);
        w_commit       = w_complete || w_flush_commit;
        frame_valid    = (w_state[r_rd_sel] == FULL);
        w_xfer         = frame_valid && frame_ready;
        frame_data     = w_data[r_rd_sel];
        frame_len      = w_len[r_rd_sel];
    end

    assign frame_seq = r_seq;
    assign ovf_cnt   = r_ovf;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic w_is_wr;
        logic w_is_rd;
        assign w_is_wr = (r_wr_sel == 1'(b));
        assign w_is_rd = (r_rd_sel == 1'(b));

        frame_bank u_bank (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_wr_en      (w_accept && w_is_wr),
            .i_wr_idx     (r_count[LIDX_W-1:0]),
            .i_wr_data    (in_data),
            .i_zero_en    (w_flush_commit && w_is_wr),
            .i_zero_from  (w_count_acc),
            .i_commit     (w_commit && w_is_wr),
            .i_commit_len (w_count_acc),
            .i_release    (w_xfer && w_is_rd),
            .o_state      (w_state[b]),
            .o_len        (w_len[b]),
            .o_data       (w_data[b])
        );
    end

    // Fill side: lane count and fill-bank select
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_wr_sel <= 1'b0;
        end else if (w_commit) begin
            r_count  <= '0;
            r_wr_sel <= !r_wr_sel;
        end else if (w_accept) begin
            r_count  <= w_count_acc;
        end
    end

    // Drain side: drain-bank select and frame sequence number
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_sel <= 1'b0;
            r_seq    <= '0;
        end else if (w_xfer) begin
            r_rd_sel <= !r_rd_sel;
            r_seq    <= r_seq + 1'b1;
        end
    end

    // Saturating count of samples offered while both banks are held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= '0;
        end else if (in_valid && !in_ready && (r_ovf != 8'hFF)) begin
            r_ovf <= r_ovf + 8'd1;
        end
    end

    // The sample bus must be known whenever it is qualified
    a_in_data_known : assert property (@(posedge clk) disable iff (!rst_n)
        in_valid |-> !$isunknown(in_data));

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// Self-checking bench for frame_seq_ctrl with a queue-based frame model.
module tb_frame_seq_ctrl;
    import frame_pkg::*;

    localparam int SEQW    = 4;
    localparam int SEQ_MOD = 1 << SEQW;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    sample_t          in_data;
    logic             flush;
    logic             frame_valid;
    logic             frame_ready;
    frame_t           frame_data;
    logic [LEN_W-1:0] frame_len;
    logic [SEQW-1:0]  frame_seq;
    logic [7:0]       ovf_cnt;

    always #5 clk = ~clk;

    frame_seq_ctrl #(.SEQW(SEQW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .flush       (flush),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_data  (frame_data),
        .frame_len   (frame_len),
        .frame_seq   (frame_seq),
        .ovf_cnt     (ovf_cnt)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Reference model: completed frames waiting for the consumer, plus the partial frame
    typedef struct {
        frame_t d;
        int     len;
    } mframe_t;

    mframe_t mq[$];
    sample_t mpart[$];
    int      mseq;
    int      movf;
    int      delivered;

    task automatic model_reset();
        mq.delete();
        mpart.delete();
        mseq = 0;
        movf = 0;
    endtask

    task automatic model_push();
        mframe_t f;
        f.d = '0;
        for (int i = 0; i < mpart.size(); i++) f.d[i] = mpart[i];
        f.len = mpart.size();
        mq.push_back(f);
        mpart.delete();
    endtask

    // One clock of the model, using the inputs currently applied
    task automatic model_step();
        bit rdy;
        rdy = (mq.size() < 2);
        if (mq.size() > 0 && frame_ready) begin
            void'(mq.pop_front());
            mseq = (mseq + 1) % SEQ_MOD;
            delivered++;
        end
        if (in_valid) begin
            if (rdy) begin
                mpart.push_back(in_data);
                if (mpart.size() == LANES) model_push();
            end else if (movf < 255) begin
                movf++;
            end
        end
        if (flush && mpart.size() > 0) model_push();
    endtask

    task automatic set_in(input logic v, input sample_t d, input logic f, input logic r);
        in_valid    = v;
        in_data     = d;
        flush       = f;
        frame_ready = r;
        #1;
    endtask

    task automatic adv();
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; flush = 1'b0; frame_ready = 1'b0;
        model_reset();
        delivered = 0;
        repeat (2) @(negedge clk);
        #1;
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end else n_pass++;
        n_chk++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_frame_valid got=%b exp=0", frame_valid); end else n_pass++;
        n_chk++; if (frame_len !== '0) begin n_fail++; $display("FAIL reset_frame_len got=%0d exp=0", frame_len); end else n_pass++;
        n_chk++; if (frame_seq !== '0 || ovf_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_counters seq=%0d ovf=%0d exp=0,0", frame_seq, ovf_cnt); end else n_pass++;
        n_chk++; if (frame_data !== '0) begin n_fail++; $display("FAIL reset_frame_data got=%h exp=0", frame_data); end else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_frame();
        frame_t exp;
        for (int i = 0; i < LANES; i++) exp[i] = sample_t'(i + 1);
        for (int i = 0; i < LANES; i++) begin
            set_in(1'b1, sample_t'(i + 1), 1'b0, 1'b1);
            n_chk++; if (frame_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL single_fill lane=%0d valid=%b ready=%b exp=0,1", i, frame_valid, in_ready); end else n_pass++;
            adv();
        end
        set_in(1'b0, '0, 1'b0, 1'b1);
        n_chk++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b exp=1", frame_valid); end else n_pass++;
        n_chk++; if (frame_data !== exp) begin n_fail++; $display("FAIL single_data got=%h exp=%h", frame_data, exp); end else n_pass++;
        n_chk++; if (frame_len !== LEN_W'(LANES) || frame_seq !== 4'd0) begin n_fail++; $display("FAIL single_len_seq len=%0d seq=%0d exp=%0d,0", frame_len, frame_seq, LANES); end else n_pass++;
        adv();
        set_in(1'b0, '0, 1'b0, 1'b0);
        n_chk++; if (frame_valid !== 1'b0 || frame_seq !== 4'd1) begin n_fail++; $display("FAIL single_after valid=%b seq=%0d exp=0,1", frame_valid, frame_seq); end else n_pass++;
        adv();
    endtask

    task automatic test_backpressure();
        frame_t exp;
        for (int k = 0; k < 3 * LANES; k++) begin
            set_in(1'b1, sample_t'(k + 1), 1'b0, 1'b0);
            n_chk++; if (in_ready !== (k < 2 * LANES)) begin n_fail++; $display("FAIL bp_in_ready offer=%0d got=%b exp=%b", k, in_ready, (k < 2 * LANES)); end else n_pass++;
            adv();
        end
        set_in(1'b0, '0, 1'b0, 1'b1);
        n_chk++; if (ovf_cnt !== 8'd8) begin n_fail++; $display("FAIL bp_ovf got=%0d exp=8", ovf_cnt); end else n_pass++;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < LANES; i++) exp[i] = sample_t'(f * LANES + i + 1);
            set_in(1'b0, '0, 1'b0, 1'b1);
            n_chk++; if (frame_valid !== 1'b1 || frame_data !== exp) begin n_fail++; $display("FAIL bp_frame%0d valid=%b got=%h exp=%h", f, frame_valid, frame_data, exp); end else n_pass++;
            n_chk++; if (frame_seq !== SEQW'(mseq)) begin n_fail++; $display("FAIL bp_seq%0d got=%0d exp=%0d", f, frame_seq, mseq); end else n_pass++;
            n_chk++; if (in_ready !== (f == 1)) begin n_fail++; $display("FAIL bp_ready_return%0d got=%b exp=%b", f, in_ready, (f == 1)); end else n_pass++;
            adv();
        end
        set_in(1'b0, '0, 1'b0, 1'b0);
        n_chk++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained got=%b exp=0", frame_valid); end else n_pass++;
    endtask

    task automatic test_flush();
        frame_t exp;
        exp = '0;
        for (int i = 0; i < 3; i++) begin
            exp[i] = sample_t'(-5 - i);
            set_in(1'b1, sample_t'(-5 - i), 1'b0, 1'b0);
            adv();
        end
        set_in(1'b0, '0, 1'b1, 1'b0);
        n_chk++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL flush_early got=%b exp=0", frame_valid); end else n_pass++;
        adv();
        set_in(1'b0, '0, 1'b0, 1'b1);
        n_chk++; if (frame_valid !== 1'b1 || frame_data !== exp) begin n_fail++; $display("FAIL flush_data valid=%b got=%h exp=%h", frame_valid, frame_data, exp); end else n_pass++;
        n_chk++; if (frame_len !== LEN_W'(3)) begin n_fail++; $display("FAIL flush_len got=%0d exp=3", frame_len); end else n_pass++;
        adv();
        set_in(1'b0, '0, 1'b1, 1'b0);
        adv();
        set_in(1'b0, '0, 1'b0, 1'b0);
        n_chk++; if (frame_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_empty valid=%b ready=%b exp=0,1", frame_valid, in_ready); end else n_pass++;
    endtask

    task automatic test_flush_with_last();
        frame_t exp;
        for (int i = 0; i < LANES; i++) begin
            exp[i] = sample_t'(50 + i);
            set_in(1'b1, sample_t'(50 + i), (i == LANES - 1), 1'b0);
            adv();
        end
        set_in(1'b0, '0, 1'b0, 1'b1);
        n_chk++; if (frame_valid !== 1'b1 || frame_data !== exp) begin n_fail++; $display("FAIL flast_data valid=%b got=%h exp=%h", frame_valid, frame_data, exp); end else n_pass++;
        n_chk++; if (frame_len !== LEN_W'(LANES)) begin n_fail++; $display("FAIL flast_len got=%0d exp=%0d", frame_len, LANES); end else n_pass++;
        adv();
        set_in(1'b0, '0, 1'b0, 1'b1);
        n_chk++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL flast_no_empty got=%b exp=0", frame_valid); end else n_pass++;
        adv();
    endtask

    task automatic test_random();
        int     target;
        int     cyc;
        logic   prev_stall;
        frame_t prev_data;
        logic [LEN_W-1:0] prev_len;
        logic [SEQW-1:0]  prev_seq;
        target     = delivered + 40;
        cyc        = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_len   = '0;
        prev_seq   = '0;
        while (delivered < target && cyc < 4000) begin
            set_in(($urandom_range(0, 3) != 0), sample_t'($urandom), ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
            n_chk++; if (in_ready !== (mq.size() < 2)) begin n_fail++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, (mq.size() < 2)); end else n_pass++;
            n_chk++; if (frame_valid !== (mq.size() > 0)) begin n_fail++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, frame_valid, (mq.size() > 0)); end else n_pass++;
            n_chk++; if (frame_seq !== SEQW'(mseq) || ovf_cnt !== 8'(movf)) begin n_fail++; $display("FAIL rnd_counters cyc=%0d seq=%0d ovf=%0d exp=%0d,%0d", cyc, frame_seq, ovf_cnt, mseq, movf); end else n_pass++;
            if (mq.size() > 0) begin
                n_chk++; if (frame_data !== mq[0].d || frame_len !== LEN_W'(mq[0].len)) begin n_fail++; $display("FAIL rnd_frame cyc=%0d got=%h len=%0d exp=%h len=%0d", cyc, frame_data, frame_len, mq[0].d, mq[0].len); end else n_pass++;
            end
            if (prev_stall) begin
                n_chk++; if (frame_data !== prev_data || frame_len !== prev_len || frame_seq !== prev_seq) begin n_fail++; $display("FAIL rnd_stable cyc=%0d got=%h/%0d/%0d exp=%h/%0d/%0d", cyc, frame_data, frame_len, frame_seq, prev_data, prev_len, prev_seq); end else n_pass++;
            end
            prev_stall = frame_valid && !frame_ready;
            prev_data  = frame_data;
            prev_len   = frame_len;
            prev_seq   = frame_seq;
            adv();
            cyc++;
        end
        n_chk++; if (delivered < target) begin n_fail++; $display("FAIL rnd_timeout delivered=%0d exp=%0d", delivered, target); end else n_pass++;
    endtask

    task automatic test_reset_midframe();
        frame_t exp;
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, sample_t'(100 + i), 1'b0, 1'b0);
            adv();
        end
        set_in(1'b0, '0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        model_reset();
        n_chk++; if (frame_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_hs valid=%b ready=%b exp=0,1", frame_valid, in_ready); end else n_pass++;
        n_chk++; if (ovf_cnt !== 8'd0 || frame_seq !== '0) begin n_fail++; $display("FAIL rstmid_counters ovf=%0d seq=%0d exp=0,0", ovf_cnt, frame_seq); end else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            exp[i] = sample_t'(200 + i);
            set_in(1'b1, sample_t'(200 + i), 1'b0, 1'b0);
            adv();
        end
        set_in(1'b0, '0, 1'b0, 1'b1);
        n_chk++; if (frame_valid !== 1'b1 || frame_data !== exp || frame_seq !== '0) begin n_fail++; $display("FAIL rstmid_frame valid=%b seq=%0d got=%h exp=%h seq0", frame_valid, frame_seq, frame_data, exp); end else n_pass++;
        adv();
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_flush();
        test_flush_with_last();
        test_random();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
